uart_rx_parity: RTL

- Asynchronous serial receiver; mates with the team's existing 8-bit UART transmitter.
- Frame format: 8 data bits LSB first, one parity bit, one stop bit.
- Shares the same baud-select encoding and parity-select convention as the transmitter. Sits between a board RX pin and the BRAM-write / command logic.
- Delivers each byte as a one-cycle valid pulse with parity and framing status.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_sync.sv | 40 ++++
 rtl/uart_rx_parity.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the team's 8-bit UART (transmitter and receiver):
//   - bit-period divider constants for a 50 MHz system clock
//   - bps_divider(): baud-select code -> bit period in clock cycles
//   - rx_state_t: receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [17:0] DIV_300   = 18'd166667;
    localparam logic [17:0] DIV_600   = 18'd83333;
    localparam logic [17:0] DIV_1200  = 18'd41667;
    localparam logic [17:0] DIV_2400  = 18'd20833;
    localparam logic [17:0] DIV_4800  = 18'd10417;
    localparam logic [17:0] DIV_9600  = 18'd5208;
    localparam logic [17:0] DIV_19200 = 18'd2604;
    localparam logic [17:0] DIV_38400 = 18'd1302;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Code 7 selects 300 baud so that the slowest rate still has a code.
    function automatic logic [17:0] bps_divider(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_600;
            3'd1:    return DIV_1200;
            3'd2:    return DIV_2400;
            3'd3:    return DIV_4800;
            3'd4:    return DIV_9600;
            3'd5:    return DIV_19200;
            3'd6:    return DIV_38400;
            default: return DIV_300;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous RX pin into the CLK_50M domain and flags the
// idle-to-start falling edge.
//   CLK_50M     in   system clock
//   rst_n       in   asynchronous active-low reset (flops reset to idle-high)
//   RX          in   raw serial line
//   rx_s        out  synchronised RX
//   fall_pulse  out  one-cycle pulse when rx_s goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_50M,
    input  logic rst_n,
    input  logic RX,
    output logic rx_s,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s       = r_sync[SYNC_STAGES-1];
    assign fall_pulse = r_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_parity.sv
// ---------------------------------------------------------------------------
// uart_rx_parity
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
//   CLK_50M     in   system clock (50 MHz)
//   rst_n       in   asynchronous active-low reset
//   bps_sel     in   baud select (see uart_pkg::bps_divider), latched at start
//   check_sel   in   parity select, 1=odd 0=even, latched at start
//   RX          in   serial line, idle high, asynchronous
//   dout        out  received byte, held until the next valid
//   valid       out  one-cycle pulse; dout and flags are fresh on this cycle
//   parity_err  out  parity mismatch on the last frame
//   frame_err   out  stop bit sampled low on the last frame
//   busy        out  high from start-edge detect until back in IDLE
// Build option: define UART_RX_MAJORITY_EN to take every bit decision as a
// 2-of-3 vote over three samples two cycles apart, decided two cycles later.
// ---------------------------------------------------------------------------
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_50M,
    input  logic       rst_n,
    input  logic [2:0] bps_sel,
    input  logic       check_sel,
    input  logic       RX,
    output logic [7:0] dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // CLK_HZ only documents the clock the divider table assumes; a
    // non-positive value falls back to the default depth as well.
    localparam int SYNC_N = (CLK_HZ <= 0 || SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [17:0] DECIDE_SHIFT = 18'd2;
`else
    localparam logic [17:0] DECIDE_SHIFT = 18'd0;
`endif

    rx_state_t   r_state, w_state_next;
    logic        w_rx_s, w_fall;
    logic [17:0] r_div, r_cnt, w_decide_at;
    logic        r_check;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift, r_dout;
    logic        r_perr, r_valid, r_parity_err, r_frame_err, r_busy;
    logic        w_tick, w_sample;

    uart_rx_sync #(.SYNC_STAGES(SYNC_N)) u_sync (
        .CLK_50M    (CLK_50M),
        .rst_n      (rst_n),
        .RX         (RX),
        .rx_s       (w_rx_s),
        .fall_pulse (w_fall)
    );

    // START decides at the half period (bit centre from the falling edge);
    // the counter is then cleared, so every later decision is one full
    // period on, again at a bit centre.
    always_comb begin
        if (r_state == ST_START) w_decide_at = (r_div >> 1) - 18'd1 + DECIDE_SHIFT;
        else                     w_decide_at = r_div - 18'd1;
    end

    assign w_tick = (r_cnt == w_decide_at);

`ifdef UART_RX_MAJORITY_EN
    logic r_tap0, r_tap1;

    // Earlier taps sit 4 and 2 cycles before the decision; the third vote
    // is the live synchronised sample on the decision cycle.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tap0 <= 1'b1;
            r_tap1 <= 1'b1;
        end else begin
            if (r_cnt == w_decide_at - 18'd4) r_tap0 <= w_rx_s;
            if (r_cnt == w_decide_at - 18'd2) r_tap1 <= w_rx_s;
        end
    end

    assign w_sample = (r_tap0 & r_tap1) | (r_tap0 & w_rx_s) | (r_tap1 & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: next state defaults to the current state before the case so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_fall) w_state_next = ST_START;
            ST_START:     if (w_tick) w_state_next = w_sample ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_tick && r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
            ST_PARITY:    if (w_tick) w_state_next = ST_STOP;
            ST_STOP:      if (w_tick) w_state_next = w_sample ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (w_rx_s) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= DIV_9600;
            r_check      <= 1'b0;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_cnt   <= w_tick ? 18'd0 : r_cnt + 18'd1;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_div     <= bps_divider(bps_sel);
                        r_check   <= check_sel;
                    end
                end
                ST_START: begin
                    // High at the start-bit centre: a glitch, not a frame.
                    if (w_tick && w_sample) r_busy <= 1'b0;
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_sample, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_tick) r_perr <= w_sample ^ (^r_shift ^ r_check);
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_dout       <= r_shift;
                        r_parity_err <= r_perr;
                        r_frame_err  <= ~w_sample;
                        r_valid      <= 1'b1;
                        if (w_sample) r_busy <= 1'b0;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start.
                    if (w_rx_s) r_busy <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule
